// File: rtl/xbar_traffic_gen_pkg.sv
// Shared types and helpers for the crossbar traffic generator.
package xbar_traffic_gen_pkg;

    // Destination pattern selected at run start
    typedef enum logic [1:0] {
        MODE_IDENT   = 2'd0,
        MODE_ROTATE  = 2'd1,
        MODE_RANDOM  = 2'd2,
        MODE_HOTSPOT = 2'd3
    } gen_mode_e;

    // Run-control states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HDR  = 3'd2,
        ST_PLD  = 3'd3,
        ST_DONE = 3'd4
    } gen_state_e;

    // Seed used when the requested RANDOM seed is zero (an all-zero LFSR never moves)
    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    // Galois feedback mask for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Header word: zero-pad, 1'b1, dest[dw], slot[sw], 1'b0, parity.
    // Parity bit makes the whole word odd-parity. Result is right-aligned in 32 bits.
    function automatic logic [31:0] make_header(input logic [15:0] dest,
                                                input logic [15:0] slot,
                                                input int unsigned dw,
                                                input int unsigned sw);
        logic [31:0] w;
        w = 32'(1) << (dw + sw + 2);
        w = w | ((32'(dest) & ((32'(1) << dw) - 32'(1))) << (sw + 2));
        w = w | ((32'(slot) & ((32'(1) << sw) - 32'(1))) << 2);
        w = w | {31'b0, ~^w};
        return w;
    endfunction

endpackage

// File: rtl/xbar_traffic_gen_if.sv
// Control and data bundle between a run controller and the traffic generator.
interface xbar_traffic_gen_if
    import xbar_traffic_gen_pkg::*;
#(
    parameter int PORTS = 8,
    parameter int SLOTS = 4,
    parameter int PKT_W = 8
);
    localparam int DW = $clog2(PORTS);

    logic                     slot_tick;
    logic                     start;
    logic                     abort;
    gen_mode_e                mode;
    logic [15:0]              num_frames;
    logic [PKT_W-1:0]         pld_seed;
    logic [15:0]              lfsr_seed;
    logic [DW-1:0]            hot_port;

    logic [PORTS*PKT_W-1:0]   data;
    logic                     hdr_phase;
    logic                     busy;
    logic                     done;
    logic [15:0]              frame_cnt;

    // Run controller side
    modport master (
        output slot_tick, start, abort, mode, num_frames, pld_seed, lfsr_seed, hot_port,
        input  data, hdr_phase, busy, done, frame_cnt
    );

    // Generator side
    modport slave (
        input  slot_tick, start, abort, mode, num_frames, pld_seed, lfsr_seed, hot_port,
        output data, hdr_phase, busy, done, frame_cnt
    );
endinterface

// File: rtl/xbar_traffic_gen_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with synchronous load and step.
module xbar_traffic_gen_lfsr16
    import xbar_traffic_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);
    logic [15:0] lfsr_q;

    // Load has priority over step; one shift per step strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_DEFAULT;
        end else if (load) begin
            lfsr_q <= seed;
        end else if (step) begin
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    assign q = lfsr_q;
endmodule

// File: rtl/xbar_traffic_gen.sv
// Multi-port packet generator: per slot one header word per port, then one
// payload word per port, paced by slot_tick and run-controlled by start/abort.
module xbar_traffic_gen
    import xbar_traffic_gen_pkg::*;
#(
    parameter int PORTS = 8,
    parameter int SLOTS = 4,
    parameter int PKT_W = 8
)(
    input  logic                clk,
    input  logic                rst,
    xbar_traffic_gen_if.slave   bus
);
    localparam int DW = $clog2(PORTS);
    localparam int SW = $clog2(SLOTS);
    localparam logic [DW:0] PORTS_W = (DW + 1)'(PORTS);

    // The header occupies 1+DW+SW+1+1 bits; it must fit the word and the helper
    if (DW + SW + 3 > PKT_W || PKT_W > 32 || PORTS < 2 || SLOTS < 2) begin : g_bad_params
        $error("xbar_traffic_gen: header (DW+SW+3 bits) does not fit PKT_W or bad PORTS/SLOTS");
    end

    gen_state_e              state_q;
    gen_mode_e               mode_q;
    logic [15:0]             num_frames_q;
    logic [15:0]             frame_cnt_q;
    logic [DW-1:0]           hot_port_q;
    logic [DW-1:0]           rot_q;
    logic [SW-1:0]           slot_q;
    logic [PKT_W-1:0]        seq_q;
    logic [PORTS*PKT_W-1:0]  data_q;
    logic                    hdr_phase_q;
    logic                    busy_q;
    logic                    done_q;

    logic [15:0]             lfsr_val;
    logic [15:0]             lfsr_seed_eff;
    logic                    lfsr_load;
    logic                    lfsr_step;

    logic                    slot_wrap;
    logic                    last_slot;
    logic [SW-1:0]           slot_d;
    logic [DW-1:0]           rot_d;
    logic [DW:0]             lfsr_low;
    logic [DW-1:0]           rnd_base;
    logic [PORTS*PKT_W-1:0]  hdr_word;
    logic [PORTS*PKT_W-1:0]  pld_word;

    // slot_q is the slot currently on the wire; slot_d is the slot the next header carries
    assign slot_wrap = (slot_q == SW'(SLOTS - 1));
    assign last_slot = slot_wrap && (frame_cnt_q == num_frames_q - 16'd1);
    assign slot_d    = (state_q == ST_PLD) ? (slot_wrap ? '0 : slot_q + SW'(1)) : slot_q;
    assign rot_d     = (rot_q == DW'(PORTS - 1)) ? '0 : rot_q + DW'(1);

    // LFSR is loaded when a run is accepted and steps on every header entry
    assign lfsr_seed_eff = (bus.lfsr_seed == 16'd0) ? LFSR_DEFAULT : bus.lfsr_seed;
    assign lfsr_load     = (state_q == ST_IDLE) && bus.start && !bus.abort;
    assign lfsr_step     = bus.slot_tick && !bus.abort &&
                           ((state_q == ST_ARM) || ((state_q == ST_PLD) && !last_slot));

    xbar_traffic_gen_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (lfsr_seed_eff),
        .step (lfsr_step),
        .q    (lfsr_val)
    );

    // Reduce the LFSR low bits below PORTS once so every per-port sum stays < 2*PORTS
    assign lfsr_low = {1'b0, lfsr_val[DW-1:0]};
    assign rnd_base = (lfsr_low >= PORTS_W) ? DW'(lfsr_low - PORTS_W) : lfsr_val[DW-1:0];

    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        localparam logic [DW:0] PORT_IDX = (DW + 1)'(gi);
        logic [DW:0]   rot_sum;
        logic [DW:0]   rnd_sum;
        logic [DW-1:0] dest;
        logic [31:0]   hdr_full;

        assign rot_sum = {1'b0, rot_q} + PORT_IDX;
        assign rnd_sum = {1'b0, rnd_base} + PORT_IDX;

        // Destination per mode; modulo PORTS by a single compare-subtract
        always_comb begin
            dest = '0;
            case (mode_q)
                MODE_IDENT:   dest = PORT_IDX[DW-1:0];
                MODE_ROTATE:  dest = (rot_sum >= PORTS_W) ? DW'(rot_sum - PORTS_W) : rot_sum[DW-1:0];
                MODE_RANDOM:  dest = (rnd_sum >= PORTS_W) ? DW'(rnd_sum - PORTS_W) : rnd_sum[DW-1:0];
                MODE_HOTSPOT: dest = hot_port_q;
                default:      dest = PORT_IDX[DW-1:0];
            endcase
        end

        assign hdr_full = make_header(16'(dest), 16'(slot_d), DW, SW);
        assign hdr_word[gi*PKT_W +: PKT_W] = hdr_full[PKT_W-1:0];
        assign pld_word[gi*PKT_W +: PKT_W] = seq_q + PKT_W'(gi);
    end

    // Run FSM with latched config, counters and registered outputs; abort beats everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_IDENT;
            num_frames_q <= '0;
            frame_cnt_q  <= '0;
            hot_port_q   <= '0;
            rot_q        <= '0;
            slot_q       <= '0;
            seq_q        <= '0;
            data_q       <= '0;
            hdr_phase_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus.abort) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            hdr_phase_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q       <= bus.mode;
                        num_frames_q <= bus.num_frames;
                        hot_port_q   <= bus.hot_port;
                        slot_q       <= '0;
                        rot_q        <= '0;
                        seq_q        <= bus.pld_seed;
                        frame_cnt_q  <= '0;
                        if (bus.num_frames == 16'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ARM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_ARM: begin
                    if (bus.slot_tick) begin
                        state_q     <= ST_HDR;
                        data_q      <= hdr_word;
                        hdr_phase_q <= 1'b1;
                        rot_q       <= rot_d;
                    end
                end
                ST_HDR: begin
                    if (bus.slot_tick) begin
                        state_q     <= ST_PLD;
                        data_q      <= pld_word;
                        hdr_phase_q <= 1'b0;
                        seq_q       <= seq_q + PKT_W'(1);
                    end
                end
                ST_PLD: begin
                    if (bus.slot_tick) begin
                        if (last_slot) begin
                            state_q     <= ST_DONE;
                            data_q      <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            state_q     <= ST_HDR;
                            data_q      <= hdr_word;
                            hdr_phase_q <= 1'b1;
                            slot_q      <= slot_d;
                            rot_q       <= rot_d;
                            if (slot_wrap) begin
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.hdr_phase = hdr_phase_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule
